vga_pos_to_node_locator: RTL and testbench
==========================================

Name: vga_pos_to_node_locator

Overview:
- Inverse of the node-count-to-VGA-position mapping: given a cursor coordinate and the current node count, finds which node slot, if any, lies under the cursor.
- Sits between the cursor/input controller and the graph-editing control FSM, which uses it to resolve node selection.
- Performs a sequential scan of one slot per clock with a req/done handshake.

Parameters:
- NODE_X, 160: x pixel coordinate of the node column centre (0..639).
- HIT_RADIUS, 8: inclusive hit tolerance in pixels on each axis.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- req  input  1  start a lookup. Sampled only in IDLE.
- num_nodes  input  5  number of nodes on screen. Valid range is 2..6.
- cursor_x  input  10  cursor x pixel, 0..639.
- cursor_y  input  9  cursor y pixel, 0..479.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the result registers are updated.
- hit  output  1  cursor lies on a node. Held until the next done.
- node_idx  output  3  index of the matched slot, 0..5. Miss or error value is 3'd7. Held until the next done.
- err  output  1  num_nodes was out of range. Held until the next done.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; busy=0, done=0, hit=0, err=0, node_idx=3'd7; scan index=0. Reset mid-scan aborts the scan with no done pulse.
- Fixed y-position table (9-bit), slot 0 first:
  - n=2: 475, 5
  - n=3: 475, 240, 5
  - n=4: 475, 318, 162, 5
  - n=5: 475, 358, 240, 122, 5
  - n=6: 473, 380, 287, 194, 101, 8
  - Table values are unused outside this mapping.
- States: IDLE and SCAN.
- IDLE, req=1 at edge E0:
  - Latch num_nodes, cursor_x and cursor_y.
  - If num_nodes is in 2..6: go to SCAN, idx=0, busy=1.
  - Otherwise: stay in IDLE; at E1 set done=1, err=1, hit=0, node_idx=7.
- SCAN: one slot is evaluated per edge. At edge E(k+1), slot k is tested:
  - Hit condition: |cursor_y - pos[k]| <= HIT_RADIUS AND |cursor_x - NODE_X| <= HIT_RADIUS.
  - Differences are computed as signed values at width 11 or more. No wrap-around is permitted.
  - On hit: hit=1, node_idx=k, err=0, done=1, busy=0, go to IDLE.
  - On miss with k=n-1: hit=0, node_idx=7, err=0, done=1, busy=0, go to IDLE.
  - On miss with k<n-1: idx=k+1.
- Priority: the first (lowest-index) matching slot wins.
- Latency:
  - Hit on slot k: done is high in the cycle after edge E(k+1).
  - Full miss: done is high in the cycle after edge E(n).
  - Error: done is high in the cycle after edge E1.
- done is high for exactly one cycle. req asserted in the same cycle as done is ignored; a new lookup may start in the following cycle.
- req while busy=1 is ignored; latched inputs are unaffected. Input changes during SCAN are ignored.
- hit, node_idx and err change only on the edge that asserts done.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- n=3, cursor=(160,242), req at E0 -> done at E2, hit=1, node_idx=1, err=0, busy high for 2 cycles.
- n=6, cursor=(165,8) -> done at E6, hit=1, node_idx=5. Then cursor=(169,8) -> hit=0, node_idx=7 at E6 (x is out by 9 pixels).
- n=4, cursor=(160,240) -> miss: done at E4, hit=0, node_idx=7. Boundary case n=2, y=483 -> hit on idx 0; y=484 -> miss.
- num_nodes=7 and num_nodes=0 -> done at E1, err=1, hit=0, node_idx=7, busy never asserted.
- req pulses while busy, plus num_nodes and cursor changed mid-scan -> result matches the originally latched lookup; exactly one done pulse.
- Assert resetn=0 during SCAN of n=6 at idx 3 -> all outputs return to reset values immediately, no done pulse; a fresh lookup after release completes correctly.

Source files
------------

// File: rtl/vga_pos_to_node_locator.sv
// Purpose : inverse of the node-count-to-VGA-position mapping. Given a latched
//           cursor coordinate and node count, scans one node slot per clock and
//           reports the first (lowest-index) slot lying under the cursor.
// Ports   :
//   clk        system clock
//   resetn     asynchronous active-low reset
//   req        start a lookup (sampled only when idle)
//   num_nodes  nodes on screen, valid 2..6
//   cursor_x   cursor x pixel, 0..639
//   cursor_y   cursor y pixel, 0..479
//   busy       scan in progress
//   done       one-cycle pulse when hit/node_idx/err are updated
//   hit        cursor lies on a node (held until next done)
//   node_idx   matched slot 0..5, 7 on miss or error (held until next done)
//   err        num_nodes was out of range (held until next done)
module vga_pos_to_node_locator #(
    parameter int unsigned NODE_X     = 160,
    parameter int unsigned HIT_RADIUS = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [4:0] num_nodes,
    input  logic [9:0] cursor_x,
    input  logic [8:0] cursor_y,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [2:0] node_idx,
    output logic       err
);

    localparam int unsigned DW       = 12;
    localparam logic [2:0]  IDX_NONE = 3'd7;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [2:0] r_n, w_n_nxt;
    logic [9:0] r_cx, w_cx_nxt;
    logic [8:0] r_cy, w_cy_nxt;
    logic       r_err_pend, w_err_pend_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_hit, w_hit_nxt;
    logic [2:0] r_node_idx, w_node_idx_nxt;
    logic       r_err, w_err_nxt;

    logic [8:0]          w_pos;
    logic signed [DW-1:0] w_dx, w_dy, w_adx, w_ady;
    logic                w_slot_match;
    logic                w_n_valid;

    // Fixed y-position of slot k for a screen of n nodes
    function automatic logic [8:0] slot_pos(input logic [2:0] n, input logic [2:0] k);
        logic [8:0] p;
        p = 9'd0;
        case (n)
            3'd2: case (k)
                3'd0: p = 9'd475;  3'd1: p = 9'd5;
                default: p = 9'd0;
            endcase
            3'd3: case (k)
                3'd0: p = 9'd475;  3'd1: p = 9'd240;  3'd2: p = 9'd5;
                default: p = 9'd0;
            endcase
            3'd4: case (k)
                3'd0: p = 9'd475;  3'd1: p = 9'd318;  3'd2: p = 9'd162;
                3'd3: p = 9'd5;
                default: p = 9'd0;
            endcase
            3'd5: case (k)
                3'd0: p = 9'd475;  3'd1: p = 9'd358;  3'd2: p = 9'd240;
                3'd3: p = 9'd122;  3'd4: p = 9'd5;
                default: p = 9'd0;
            endcase
            3'd6: case (k)
                3'd0: p = 9'd473;  3'd1: p = 9'd380;  3'd2: p = 9'd287;
                3'd3: p = 9'd194;  3'd4: p = 9'd101;  3'd5: p = 9'd8;
                default: p = 9'd0;
            endcase
            default: p = 9'd0;
        endcase
        return p;
    endfunction

    // Slot-under-cursor test on the latched coordinate; signed diffs avoid wrap
    always_comb begin
        w_pos        = slot_pos(r_n, r_idx);
        w_dx         = signed'(DW'(r_cx)) - signed'(DW'(NODE_X));
        w_dy         = signed'(DW'(r_cy)) - signed'(DW'(w_pos));
        w_adx        = (w_dx < 0) ? -w_dx : w_dx;
        w_ady        = (w_dy < 0) ? -w_dy : w_dy;
        w_slot_match = (w_adx <= signed'(DW'(HIT_RADIUS))) &&
                       (w_ady <= signed'(DW'(HIT_RADIUS)));
    end

    assign w_n_valid = (num_nodes >= 5'd2) && (num_nodes <= 5'd6);

    // State and datapath register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_n        <= 3'd0;
            r_cx       <= 10'd0;
            r_cy       <= 9'd0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_node_idx <= IDX_NONE;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_n        <= w_n_nxt;
            r_cx       <= w_cx_nxt;
            r_cy       <= w_cy_nxt;
            r_err_pend <= w_err_pend_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_hit      <= w_hit_nxt;
            r_node_idx <= w_node_idx_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_n_nxt        = r_n;
        w_cx_nxt       = r_cx;
        w_cy_nxt       = r_cy;
        w_err_pend_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_hit_nxt      = r_hit;
        w_node_idx_nxt = r_node_idx;
        w_err_nxt      = r_err;

        case (r_state)
            S_IDLE: begin
                if (r_err_pend) begin
                    // Out-of-range count reported one edge after the request
                    w_done_nxt     = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_hit_nxt      = 1'b0;
                    w_node_idx_nxt = IDX_NONE;
                end else if (req && !r_done) begin
                    w_n_nxt  = 3'(num_nodes);
                    w_cx_nxt = cursor_x;
                    w_cy_nxt = cursor_y;
                    if (w_n_valid) begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = 3'd0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_err_pend_nxt = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (w_slot_match) begin
                    w_hit_nxt      = 1'b1;
                    w_node_idx_nxt = r_idx;
                    w_err_nxt      = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else if (r_idx == r_n - 3'd1) begin
                    w_hit_nxt      = 1'b0;
                    w_node_idx_nxt = IDX_NONE;
                    w_err_nxt      = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hit      = r_hit;
    assign node_idx = r_node_idx;
    assign err      = r_err;

endmodule

// File: tb/tb_vga_pos_to_node_locator.sv
// Purpose : directed self-checking bench for vga_pos_to_node_locator.
// Ports   : none (top-level bench).
module tb_vga_pos_to_node_locator;

    logic       clk;
    logic       resetn;
    logic       req;
    logic [4:0] num_nodes;
    logic [9:0] cursor_x;
    logic [8:0] cursor_y;
    logic       busy;
    logic       done;
    logic       hit;
    logic [2:0] node_idx;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int lat;
    int bcyc;
    int ndone;

    vga_pos_to_node_locator #(
        .NODE_X    (160),
        .HIT_RADIUS(8)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .num_nodes(num_nodes),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy),
        .done     (done),
        .hit      (hit),
        .node_idx (node_idx),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Issue one lookup; lat = edges after E0 until done (-1 on timeout),
    // bc = sampled cycles with busy high. With disturb, inputs and req are
    // scrambled during the scan and req stays high through the done cycle.
    task automatic lookup(input logic [4:0] n, input logic [9:0] x, input logic [8:0] y,
                          input bit disturb, output int lt, output int bc);
        lt = -1;
        bc = 0;
        @(negedge clk);
        req       = 1'b1;
        num_nodes = n;
        cursor_x  = x;
        cursor_y  = y;
        @(negedge clk);
        req = 1'b0;
        if (busy) bc++;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                lt = c;
                req = disturb ? 1'b1 : 1'b0;
                break;
            end
            if (busy) bc++;
            if (disturb) begin
                req       = ~req;
                num_nodes = 5'd2;
                cursor_x  = 10'd160;
                cursor_y  = 9'd475;
            end
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req       = 1'b0;
        num_nodes = 5'd0;
        cursor_x  = 10'd0;
        cursor_y  = 9'd0;
        repeat (2) @(negedge clk);

        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_hit",  32'(hit), 0);
        check("rst_err",  32'(err), 0);
        check("rst_idx",  32'(node_idx), 7);
        resetn = 1'b1;

        // n=3 hit on slot 1 (y 242 vs 240)
        lookup(5'd3, 10'd160, 9'd242, 1'b0, lat, bcyc);
        check("n3_lat",  32'(lat), 2);
        check("n3_busy", 32'(bcyc), 2);
        check("n3_hit",  32'(hit), 1);
        check("n3_idx",  32'(node_idx), 1);
        check("n3_err",  32'(err), 0);
        cursor_y = 9'd5;
        @(negedge clk);
        check("n3_done_pulse", 32'(done), 0);
        check("n3_hold_hit",   32'(hit), 1);
        check("n3_hold_idx",   32'(node_idx), 1);

        // n=6 last slot, x within tolerance then just outside
        lookup(5'd6, 10'd165, 9'd8, 1'b0, lat, bcyc);
        check("n6_lat", 32'(lat), 6);
        check("n6_hit", 32'(hit), 1);
        check("n6_idx", 32'(node_idx), 5);
        lookup(5'd6, 10'd169, 9'd8, 1'b0, lat, bcyc);
        check("n6x_lat", 32'(lat), 6);
        check("n6x_hit", 32'(hit), 0);
        check("n6x_idx", 32'(node_idx), 7);

        // n=4 full miss between slots
        lookup(5'd4, 10'd160, 9'd240, 1'b0, lat, bcyc);
        check("n4_lat",  32'(lat), 4);
        check("n4_busy", 32'(bcyc), 4);
        check("n4_hit",  32'(hit), 0);
        check("n4_idx",  32'(node_idx), 7);

        // y tolerance boundary on slot 0 of n=2
        lookup(5'd2, 10'd160, 9'd483, 1'b0, lat, bcyc);
        check("y483_lat", 32'(lat), 1);
        check("y483_hit", 32'(hit), 1);
        check("y483_idx", 32'(node_idx), 0);
        lookup(5'd2, 10'd160, 9'd484, 1'b0, lat, bcyc);
        check("y484_lat", 32'(lat), 2);
        check("y484_hit", 32'(hit), 0);
        check("y484_idx", 32'(node_idx), 7);

        // Out-of-range node counts
        lookup(5'd7, 10'd160, 9'd475, 1'b0, lat, bcyc);
        check("n7_lat",  32'(lat), 1);
        check("n7_busy", 32'(bcyc), 0);
        check("n7_err",  32'(err), 1);
        check("n7_hit",  32'(hit), 0);
        check("n7_idx",  32'(node_idx), 7);
        lookup(5'd0, 10'd160, 9'd475, 1'b0, lat, bcyc);
        check("n0_lat",  32'(lat), 1);
        check("n0_busy", 32'(bcyc), 0);
        check("n0_err",  32'(err), 1);
        check("n0_idx",  32'(node_idx), 7);

        // Valid lookup clears err; x at exactly -8 from the column
        lookup(5'd2, 10'd152, 9'd5, 1'b0, lat, bcyc);
        check("xm8_lat", 32'(lat), 2);
        check("xm8_hit", 32'(hit), 1);
        check("xm8_idx", 32'(node_idx), 1);
        check("xm8_err", 32'(err), 0);

        // Disturbed scan: result follows the latched request only
        lookup(5'd6, 10'd165, 9'd8, 1'b1, lat, bcyc);
        check("dist_lat", 32'(lat), 6);
        check("dist_hit", 32'(hit), 1);
        check("dist_idx", 32'(node_idx), 5);
        @(negedge clk);
        req = 1'b0;
        check("dist_req_at_done_ignored", 32'(busy), 0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("dist_extra_done", 32'(ndone), 0);

        // Reset in the middle of an n=6 scan at slot 3
        @(negedge clk);
        req       = 1'b1;
        num_nodes = 5'd6;
        cursor_x  = 10'd300;
        cursor_y  = 9'd8;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_hit",  32'(hit), 0);
        check("mrst_err",  32'(err), 0);
        check("mrst_idx",  32'(node_idx), 7);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("mrst_no_done", 32'(ndone), 0);

        lookup(5'd5, 10'd160, 9'd122, 1'b0, lat, bcyc);
        check("post_lat", 32'(lat), 4);
        check("post_hit", 32'(hit), 1);
        check("post_idx", 32'(node_idx), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
